// File: rtl/vram_ctrl_if.sv
// Host-side bus of the video RAM controller: buffered byte writes,
// block-fill command and the status signals returned to the host.
interface vram_ctrl_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] fill_len;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output fill_start, fill_addr, fill_len, fill_value,
        input  wr_ready, fill_busy, fifo_level
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  fill_start, fill_addr, fill_len, fill_value,
        output wr_ready, fill_busy, fifo_level
    );
endinterface

// File: rtl/vram_ctrl.sv
// Video RAM controller: dual-port frame memory with a never-stalled
// read-first video port and a host write port fed by a small write FIFO
// or by a block-fill engine. Single clock domain (dot clock).
module vram_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              dot_clock,
    input  logic              sys_reset,
    input  logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data,
    vram_ctrl_if.slave        host
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [LVL_W-1:0]  count, count_next;
    logic              push, pop, full_next;

    state_t            state;
    logic [ADDR_W-1:0] fill_ptr, fill_remain;
    logic [DATA_W-1:0] fill_val;
    logic              wr_ready_q, fill_busy_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;

    assign push       = host.wr_valid & wr_ready_q;
    // The fill engine owns port B during FILL, so the FIFO only drains elsewhere.
    assign pop        = (state != FILL) && (count != '0);
    assign count_next = count + LVL_W'(push) - LVL_W'(pop);
    assign full_next  = (count_next == FULL_LVL);

    assign host.wr_ready   = wr_ready_q;
    assign host.fill_busy  = fill_busy_q;
    assign host.fifo_level = count;

    // Port B write mux: fill engine in FILL, FIFO head otherwise.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        ram_we   = 1'b0;
        ram_addr = fifo_mem[rd_ptr].addr;
        ram_din  = fifo_mem[rd_ptr].data;
        if (state == FILL) begin
            ram_we   = 1'b1;
            ram_addr = fill_ptr;
            ram_din  = fill_val;
        end else if (pop) begin
            ram_we = 1'b1;
        end
    end

    // Port B: host write port of the frame memory.
    // NOTE: RAM and FIFO storage carry no reset so they map onto memory primitives;
    // only the control state around them is reset.
    always_ff @(posedge dot_clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    // Port A: video read every cycle; read-first because the read samples the old word.
    always_ff @(posedge dot_clock or negedge sys_reset) begin
        if (!sys_reset) vram_data <= '0;
        else            vram_data <= mem[vram_addr];
    end

    // FIFO storage write side.
    always_ff @(posedge dot_clock) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: host.wr_addr, data: host.wr_data};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge dot_clock or negedge sys_reset) begin
        if (!sys_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Port B ownership FSM with registered wr_ready / fill_busy.
    always_ff @(posedge dot_clock or negedge sys_reset) begin
        if (!sys_reset) begin
            state       <= IDLE;
            wr_ready_q  <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_ptr    <= '0;
            fill_remain <= '0;
            fill_val    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_ready_q <= !full_next;
                    if (host.fill_start) begin
                        fill_ptr    <= host.fill_addr;
                        fill_remain <= host.fill_len;
                        fill_val    <= host.fill_value;
                        fill_busy_q <= 1'b1;
                        if (count_next != '0) begin
                            state      <= DRAIN;
                            wr_ready_q <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                DRAIN: begin
                    // No pushes happen here, so the entry popped with count 1 is the last.
                    if (count == LVL_W'(1)) begin
                        state      <= FILL;
                        wr_ready_q <= !full_next;
                    end else begin
                        wr_ready_q <= 1'b0;
                    end
                end
                FILL: begin
                    wr_ready_q  <= !full_next;
                    fill_ptr    <= fill_ptr + 1'b1;
                    fill_remain <= fill_remain - 1'b1;
                    if (fill_remain == '0) begin
                        state       <= IDLE;
                        fill_busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
